mnist_image_buffer: RTL and testbench
=====================================

Name: mnist_image_buffer

Overview:
- Pixel store between the drawing-grid input path and the neural-network inference engine.
- Accepts single-pixel paint/erase writes from the grid over a valid/ready handshake, holding a 28x28 binary image in a dual-port RAM.
- Serves the network's word-addressed reads as Q16.16 fixed-point words.
- Tracks a live count of set pixels, runs a full clear sweep on request or after reset, and blocks all writes while the network holds the lock.

Parameters:
- IMG_DIM, 28: image side length in pixels.
- DATA_W, 32: width of the read data word.
- ADDR_W, 16: width of the read address.
- ONE_VALUE, 32'h0001_0000: word returned for a set pixel (1.0 in Q16.16).

Ports:
- CLOCK_50  in  1  system clock.
- resetn  in  1  reset, asynchronous, active-high.
- clear_req  in  1  single-cycle pulse; requests a full image clear.
- lock  in  1  high while the network is reading; blocks writes and clears.
- wr_valid  in  1  write request valid.
- wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
- wr_x  in  5  pixel column.
- wr_y  in  5  pixel row.
- wr_value  in  1  1 = paint, 0 = erase.
- read_addr  in  ADDR_W  pixel index y*IMG_DIM+x from the network.
- data_out  out  DATA_W  ONE_VALUE if the pixel is set, else 0.
- clearing  out  1  high during a clear sweep.
- pixel_count  out  10  number of set pixels, 0..784.

Behaviour:
- Reset, asynchronous, with resetn high:
  - wr_ready=0, clearing=1, pixel_count=0, data_out=0, clear_pending=0.
  - FSM goes to CLEAR with sweep address 0.
  - RAM contents are not reset.
- FSM states: CLEAR, IDLE, RD, WR; BRUSH_NEXT exists only with the optional feature.
- CLEAR:
  - Writes 0 to one address per cycle, from 0 to 783; clearing=1 throughout.
  - The sweep lasts 784 cycles, then goes to IDLE with pixel_count=0.
  - clear_req is ignored in this state; wr_ready=0.
- IDLE:
  - wr_ready = !lock && !clear_pending && !clear_req.
  - clear_req with lock low goes to CLEAR next cycle and takes priority over a simultaneous wr_valid, which is not accepted.
  - clear_req with lock high sets clear_pending. The pending clear starts the first cycle lock is low and takes priority over writes.
  - An accepted write latches x, y and value, then goes to RD.
  - If x>=28 or y>=28 the write is accepted and discarded: stay in IDLE with no RAM access.
- RD: issues a port-A read of y*28+x. wr_ready=0. Next state WR.
- WR:
  - Writes wr_value to the latched address.
  - Updates pixel_count: +1 if old=0 and new=1; -1 if old=1 and new=0; otherwise unchanged.
  - Next state IDLE.
  - Accept-to-accept throughput is 3 cycles.
- Read port (port B) is independent of the FSM:
  - data_out is registered, 1-cycle latency after read_addr.
  - read_addr >= 784 returns 0 on the next cycle.
  - Reads during CLEAR return current RAM contents; the network guarantees no reads then.
- lock rising during RD/WR: the in-flight write completes; lock only gates new acceptance.
- pixel_count saturates at 784 and never underflows. Both are unreachable by construction but are guarded in RTL.
- Reset mid-sweep or mid-write: aborts immediately and restarts CLEAR from address 0.

Optional Feature:
- Macro: MNIST_IMG_BRUSH_3X3_EN.
- Defined:
  - Each accepted in-range write paints the 3x3 neighbourhood centred on (x,y), clipped at image edges.
  - Neighbours are processed in row-major order, dy -1..1 then dx -1..1.
  - Each neighbour takes one RD+WR pair; BRUSH_NEXT advances the offset and skips out-of-range neighbours with no RAM access.
  - wr_ready stays 0 until all neighbours finish.
- Undefined: single-pixel write as above; the BRUSH_NEXT state and offset counters are absent.

Decomposition:
- Package mnist_img_pkg:
  - IMG_DIM, NUM_PIXELS=784, ONE_Q16 constant.
  - FSM state enum.
  - A function computing y*IMG_DIM+x.
- Sub-module mnist_pixel_ram: 784x1 simple dual-port RAM.
  - Port A: synchronous read/write, used by the FSM.
  - Port B: synchronous read feeding data_out.

Test Plan:
- Release reset -> clearing=1 for exactly 784 cycles, then clearing=0, wr_ready=1, pixel_count=0; all reads of 0..783 return 0.
- Write (x=3,y=2,value=1) -> wr_ready low for 2 cycles; pixel_count=1; read_addr=59 gives data_out=0x00010000 one cycle later; read_addr=58 gives 0.
- Repeat the same write (value 1) -> pixel_count stays 1; then write value 0 -> pixel_count=0 and addr 59 reads 0.
- Write x=28,y=0 -> accepted in one cycle, no RAM change, pixel_count unchanged; read_addr=800 -> data_out=0.
- lock=1, pulse clear_req -> wr_ready=0, clearing=0 while locked; on lock=0 the sweep starts next cycle (784 cycles) and pixel_count ends at 0. clear_req and wr_valid in the same IDLE cycle -> write not accepted.
- With MNIST_IMG_BRUSH_3X3_EN, write (0,0,1) on an empty image -> pixels 0, 1, 28, 29 set and pixel_count=4; write (5,5,1) -> pixel_count=13.

Source files
------------

// File: rtl/mnist_img_pkg.sv
// rtl/mnist_img_pkg.sv - shared constants, FSM state type and pixel address helper for the MNIST image buffer
// Optional feature macro: MNIST_IMG_BRUSH_3X3_EN (adds the BRUSH_NEXT state).
package mnist_img_pkg;

    localparam int          IMG_DIM    = 28;
    localparam logic [9:0]  NUM_PIXELS = 10'd784;
    localparam logic [31:0] ONE_Q16    = 32'h0001_0000;

`ifdef MNIST_IMG_BRUSH_3X3_EN
    typedef enum logic [2:0] {
        ST_CLEAR      = 3'd0,
        ST_IDLE       = 3'd1,
        ST_RD         = 3'd2,
        ST_WR         = 3'd3,
        ST_BRUSH_NEXT = 3'd4
    } state_e;
`else
    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_RD    = 2'd2,
        ST_WR    = 2'd3
    } state_e;
`endif

    // Linear pixel index y*IMG_DIM+x; callers guarantee x,y < IMG_DIM.
    function automatic logic [9:0] pix_addr(input logic [4:0] x, input logic [4:0] y);
        return 10'(y) * 10'(IMG_DIM) + 10'(x);
    endfunction

endpackage

// File: rtl/mnist_image_buffer_if.sv
// rtl/mnist_image_buffer_if.sv - pixel write handshake from the drawing grid
// Signals: wr_valid, wr_ready, wr_x[4:0], wr_y[4:0], wr_value.
// master = grid side (drives the request), slave = image buffer.
interface mnist_image_buffer_if;
    logic       wr_valid;
    logic       wr_ready;
    logic [4:0] wr_x;
    logic [4:0] wr_y;
    logic       wr_value;

    modport master (
        output wr_valid, wr_x, wr_y, wr_value,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_value,
        output wr_ready
    );
endinterface

// File: rtl/mnist_pixel_ram.sv
// rtl/mnist_pixel_ram.sv - 784x1 simple dual-port pixel RAM
// Ports: CLOCK_50, resetn (async, active-high, read-B register only)
//        port A: i_addr_a, i_we_a, i_din_a, o_q_a (sync read/write, read-before-write)
//        port B: i_addr_b, o_q_b (sync read, out-of-range addresses return 0)
module mnist_pixel_ram
    import mnist_img_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              CLOCK_50,
    input  logic              resetn,
    input  logic [9:0]        i_addr_a,
    input  logic              i_we_a,
    input  logic              i_din_a,
    output logic              o_q_a,
    input  logic [ADDR_W-1:0] i_addr_b,
    output logic              o_q_b
);

    logic r_mem [0:NUM_PIXELS-1];
    logic r_q_a;
    logic r_q_b;

    // Storage is intentionally not reset; the controller sweeps it clear.
    always_ff @(posedge CLOCK_50) begin
        if (i_we_a) begin
            r_mem[i_addr_a] <= i_din_a;
        end
        r_q_a <= r_mem[i_addr_a];
    end

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            r_q_b <= 1'b0;
        end else if (i_addr_b < ADDR_W'(NUM_PIXELS)) begin
            r_q_b <= r_mem[i_addr_b[9:0]];
        end else begin
            r_q_b <= 1'b0;
        end
    end

    assign o_q_a = r_q_a;
    assign o_q_b = r_q_b;

endmodule

// File: rtl/mnist_image_buffer.sv
// rtl/mnist_image_buffer.sv - 28x28 binary image store between drawing grid and inference engine
// Ports: CLOCK_50, resetn (async, active-high), clear_req, lock,
//        wr (mnist_image_buffer_if.slave: wr_valid/wr_ready/wr_x/wr_y/wr_value),
//        read_addr -> data_out (1-cycle latency, Q16.16 1.0 or 0), clearing, pixel_count.
// Optional feature macro: MNIST_IMG_BRUSH_3X3_EN (3x3 brush around each written pixel).
module mnist_image_buffer
    import mnist_img_pkg::*;
#(
    parameter int                IMG_DIM   = 28,
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 16,
    parameter logic [DATA_W-1:0] ONE_VALUE = 32'h0001_0000
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic                clear_req,
    input  logic                lock,
    mnist_image_buffer_if.slave wr,
    input  logic [ADDR_W-1:0]   read_addr,
    output logic [DATA_W-1:0]   data_out,
    output logic                clearing,
    output logic [9:0]          pixel_count
);

    state_e     r_state;
    logic [9:0] r_sweep;
    logic [9:0] r_addr;
    logic       r_val;
    logic       r_pending;
    logic       r_clearing;
    logic [9:0] r_count;

    logic       w_accept;
    logic       w_in_range;
    logic       w_start_clear;
    logic [9:0] w_a_addr;
    logic       w_a_we;
    logic       w_a_din;
    logic       w_q_a;
    logic       w_q_b;

`ifdef MNIST_IMG_BRUSH_3X3_EN
    logic [4:0] r_cx;
    logic [4:0] r_cy;
    logic [1:0] r_ox;
    logic [1:0] r_oy;
    logic [5:0] w_nx;
    logic [5:0] w_ny;
    logic       w_nb_in_range;
    logic       w_nb_last;

    // Offsets 0..2 map to -1..+1; a negative coordinate wraps to 63 and fails the range test.
    assign w_nx          = {1'b0, r_cx} + {4'b0, r_ox} - 6'd1;
    assign w_ny          = {1'b0, r_cy} + {4'b0, r_oy} - 6'd1;
    assign w_nb_in_range = (int'(w_nx) < IMG_DIM) && (int'(w_ny) < IMG_DIM);
    assign w_nb_last     = (r_ox == 2'd2) && (r_oy == 2'd2);
`endif

    // A clear (fresh or deferred) wins over any write in the same cycle.
    assign w_start_clear = (r_state == ST_IDLE) && (clear_req || r_pending) && !lock;
    assign wr.wr_ready   = (r_state == ST_IDLE) && !lock && !r_pending && !clear_req;
    assign w_accept      = wr.wr_valid && wr.wr_ready;
    assign w_in_range    = (int'(wr.wr_x) < IMG_DIM) && (int'(wr.wr_y) < IMG_DIM);

    assign w_a_addr = (r_state == ST_CLEAR) ? r_sweep : r_addr;
    assign w_a_we   = (r_state == ST_CLEAR) || (r_state == ST_WR);
    assign w_a_din  = (r_state == ST_WR) ? r_val : 1'b0;

    always_ff @(posedge CLOCK_50 or posedge resetn) begin
        if (resetn) begin
            r_state    <= ST_CLEAR;
            r_sweep    <= '0;
            r_addr     <= '0;
            r_val      <= 1'b0;
            r_pending  <= 1'b0;
            r_clearing <= 1'b1;
            r_count    <= '0;
`ifdef MNIST_IMG_BRUSH_3X3_EN
            r_cx       <= '0;
            r_cy       <= '0;
            r_ox       <= '0;
            r_oy       <= '0;
`endif
        end else begin
            // Remember clear requests that arrive while a write is in flight or the lock is held.
            if (clear_req && (r_state != ST_CLEAR)) begin
                r_pending <= 1'b1;
            end

            case (r_state)
                ST_CLEAR: begin
                    if (r_sweep == NUM_PIXELS - 10'd1) begin
                        r_state    <= ST_IDLE;
                        r_clearing <= 1'b0;
                        r_count    <= '0;
                        r_sweep    <= '0;
                    end else begin
                        r_sweep <= r_sweep + 10'd1;
                    end
                end

                ST_IDLE: begin
                    if (w_start_clear) begin
                        r_state    <= ST_CLEAR;
                        r_clearing <= 1'b1;
                        r_sweep    <= '0;
                        r_pending  <= 1'b0;
                    end else if (w_accept && w_in_range) begin
                        r_val <= wr.wr_value;
`ifdef MNIST_IMG_BRUSH_3X3_EN
                        r_cx    <= wr.wr_x;
                        r_cy    <= wr.wr_y;
                        r_ox    <= '0;
                        r_oy    <= '0;
                        r_state <= ST_BRUSH_NEXT;
`else
                        r_addr  <= pix_addr(wr.wr_x, wr.wr_y);
                        r_state <= ST_RD;
`endif
                    end
                end

                ST_RD: begin
                    r_state <= ST_WR;
                end

                ST_WR: begin
                    if (!w_q_a && r_val && (r_count != NUM_PIXELS)) begin
                        r_count <= r_count + 10'd1;
                    end else if (w_q_a && !r_val && (r_count != 10'd0)) begin
                        r_count <= r_count - 10'd1;
                    end
`ifdef MNIST_IMG_BRUSH_3X3_EN
                    if (w_nb_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state <= ST_BRUSH_NEXT;
                        if (r_ox == 2'd2) begin
                            r_ox <= '0;
                            r_oy <= r_oy + 2'd1;
                        end else begin
                            r_ox <= r_ox + 2'd1;
                        end
                    end
`else
                    r_state <= ST_IDLE;
`endif
                end

`ifdef MNIST_IMG_BRUSH_3X3_EN
                ST_BRUSH_NEXT: begin
                    if (w_nb_in_range) begin
                        r_addr  <= pix_addr(w_nx[4:0], w_ny[4:0]);
                        r_state <= ST_RD;
                    end else if (w_nb_last) begin
                        r_state <= ST_IDLE;
                    end else if (r_ox == 2'd2) begin
                        r_ox <= '0;
                        r_oy <= r_oy + 2'd1;
                    end else begin
                        r_ox <= r_ox + 2'd1;
                    end
                end
`endif

                default: begin
                    r_state <= ST_CLEAR;
                    r_sweep <= '0;
                end
            endcase
        end
    end

    mnist_pixel_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .i_addr_a (w_a_addr),
        .i_we_a   (w_a_we),
        .i_din_a  (w_a_din),
        .o_q_a    (w_q_a),
        .i_addr_b (read_addr),
        .o_q_b    (w_q_b)
    );

    assign data_out    = w_q_b ? ONE_VALUE : '0;
    assign clearing    = r_clearing;
    assign pixel_count = r_count;

endmodule

// File: tb/tb_mnist_image_buffer.sv
// tb/tb_mnist_image_buffer.sv - directed self-checking bench for mnist_image_buffer
module tb_mnist_image_buffer;

    logic        clk;
    logic        resetn;
    logic        clear_req;
    logic        lock;
    logic [15:0] read_addr;
    logic [31:0] data_out;
    logic        clearing;
    logic [9:0]  pixel_count;

    int total;
    int bad;

    mnist_image_buffer_if wr_if ();

    mnist_image_buffer dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .clear_req   (clear_req),
        .lock        (lock),
        .wr          (wr_if.slave),
        .read_addr   (read_addr),
        .data_out    (data_out),
        .clearing    (clearing),
        .pixel_count (pixel_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts clock edges until clearing drops; gives up after 2000.
    task automatic wait_clear_done(output int n);
        n = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!clearing) break;
            step();
            n++;
        end
    endtask

    // Presents a write, waits for acceptance, returns number of cycles wr_ready then stays low.
    task automatic do_write(input logic [4:0] x, input logic [4:0] y, input logic v,
                            output bit ok, output int low_cycles);
        ok = 0;
        low_cycles = -1;
        wr_if.wr_x = x;
        wr_if.wr_y = y;
        wr_if.wr_value = v;
        wr_if.wr_valid = 1'b1;
        #1;
        for (int i = 0; i < 20; i++) begin
            if (wr_if.wr_ready) begin
                ok = 1;
                break;
            end
            step();
        end
        step();
        wr_if.wr_valid = 1'b0;
        #1;
        if (ok) begin
            low_cycles = 0;
            for (int i = 0; i < 20; i++) begin
                if (wr_if.wr_ready) break;
                step();
                low_cycles++;
            end
        end
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        read_addr = a;
        step();
        d = data_out;
    endtask

    task automatic test_reset();
        resetn = 1'b1;
        step();
        step();
        total++;
        if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL reset_wr_ready got=%0b exp=0", wr_if.wr_ready); end
        total++;
        if (clearing !== 1'b1) begin bad++; $display("FAIL reset_clearing got=%0b exp=1", clearing); end
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", pixel_count); end
        total++;
        if (data_out !== 32'h0) begin bad++; $display("FAIL reset_data_out got=%h exp=0", data_out); end
    endtask

    task automatic test_clear_sweep();
        int n;
        resetn = 1'b0;
        wait_clear_done(n);
        total++;
        if (n != 784) begin bad++; $display("FAIL sweep_len got=%0d exp=784", n); end
        total++;
        if (wr_if.wr_ready !== 1'b1) begin bad++; $display("FAIL post_sweep_ready got=%0b exp=1", wr_if.wr_ready); end
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL post_sweep_count got=%0d exp=0", pixel_count); end
    endtask

    task automatic test_reset_mid_sweep();
        int n;
        bit ok;
        int lc;
        // Paint one pixel so a skipped sweep would be visible.
        do_write(5'd7, 5'd0, 1'b1, ok, lc);
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        for (int i = 0; i < 100; i++) step();
        resetn = 1'b1;
        step();
        resetn = 1'b0;
        wait_clear_done(n);
        total++;
        if (n != 784) begin bad++; $display("FAIL mid_sweep_restart got=%0d exp=784", n); end
    endtask

    task automatic test_read_all_zero();
        logic [31:0] d;
        int errs;
        errs = 0;
        for (int a = 0; a < 784; a++) begin
            rd(16'(a), d);
            if (d !== 32'h0) errs++;
        end
        total++;
        if (errs != 0) begin bad++; $display("FAIL read_all_zero nonzero_words=%0d exp=0", errs); end
    endtask

`ifndef MNIST_IMG_BRUSH_3X3_EN
    task automatic test_write_single();
        bit ok;
        int lc;
        logic [31:0] d;
        do_write(5'd3, 5'd2, 1'b1, ok, lc);
        total++;
        if (!ok) begin bad++; $display("FAIL write_accept got=0 exp=1"); end
        total++;
        if (lc != 2) begin bad++; $display("FAIL write_ready_low got=%0d exp=2", lc); end
        total++;
        if (pixel_count !== 10'd1) begin bad++; $display("FAIL write_count got=%0d exp=1", pixel_count); end
        rd(16'd59, d);
        total++;
        if (d !== 32'h0001_0000) begin bad++; $display("FAIL read_59 got=%h exp=00010000", d); end
        rd(16'd58, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL read_58 got=%h exp=0", d); end
    endtask

    task automatic test_repeat_and_erase();
        bit ok;
        int lc;
        logic [31:0] d;
        do_write(5'd3, 5'd2, 1'b1, ok, lc);
        total++;
        if (pixel_count !== 10'd1) begin bad++; $display("FAIL repeat_count got=%0d exp=1", pixel_count); end
        do_write(5'd3, 5'd2, 1'b0, ok, lc);
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL erase_count got=%0d exp=0", pixel_count); end
        rd(16'd59, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL erase_read got=%h exp=0", d); end
        // Erasing an already clear pixel must not underflow.
        do_write(5'd3, 5'd2, 1'b0, ok, lc);
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL erase_twice_count got=%0d exp=0", pixel_count); end
        // Corner pixel 783.
        do_write(5'd27, 5'd27, 1'b1, ok, lc);
        rd(16'd783, d);
        total++;
        if (d !== 32'h0001_0000) begin bad++; $display("FAIL read_783 got=%h exp=00010000", d); end
        do_write(5'd27, 5'd27, 1'b0, ok, lc);
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL corner_erase_count got=%0d exp=0", pixel_count); end
    endtask

    task automatic test_out_of_range();
        bit ok;
        int lc;
        logic [31:0] d;
        do_write(5'd28, 5'd0, 1'b1, ok, lc);
        total++;
        if (!ok || lc != 0) begin bad++; $display("FAIL oor_accept ok=%0b low=%0d exp ok=1 low=0", ok, lc); end
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL oor_count got=%0d exp=0", pixel_count); end
        rd(16'd28, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL oor_alias_read got=%h exp=0", d); end
        do_write(5'd0, 5'd31, 1'b1, ok, lc);
        total++;
        if (!ok || lc != 0 || pixel_count !== 10'd0) begin
            bad++; $display("FAIL oor_y ok=%0b low=%0d count=%0d exp 1/0/0", ok, lc, pixel_count);
        end
        rd(16'd800, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL read_800 got=%h exp=0", d); end
    endtask

    task automatic test_lock_clear();
        bit ok;
        int lc;
        int n;
        logic [31:0] d;
        do_write(5'd10, 5'd10, 1'b1, ok, lc);
        total++;
        if (pixel_count !== 10'd1) begin bad++; $display("FAIL lock_pre_count got=%0d exp=1", pixel_count); end
        lock = 1'b1;
        wr_if.wr_x = 5'd4;
        wr_if.wr_y = 5'd4;
        wr_if.wr_value = 1'b1;
        wr_if.wr_valid = 1'b1;
        #1;
        total++;
        if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL lock_blocks_ready got=%0b exp=0", wr_if.wr_ready); end
        step();
        step();
        step();
        wr_if.wr_valid = 1'b0;
        total++;
        if (pixel_count !== 10'd1) begin bad++; $display("FAIL lock_blocked_count got=%0d exp=1", pixel_count); end
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step();
        step();
        total++;
        if (clearing !== 1'b0 || wr_if.wr_ready !== 1'b0) begin
            bad++; $display("FAIL locked_pending clearing=%0b ready=%0b exp 0/0", clearing, wr_if.wr_ready);
        end
        lock = 1'b0;
        #1;
        total++;
        if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL pending_ready got=%0b exp=0", wr_if.wr_ready); end
        step();
        total++;
        if (clearing !== 1'b1) begin bad++; $display("FAIL pending_start got=%0b exp=1", clearing); end
        wait_clear_done(n);
        total++;
        if (n != 784) begin bad++; $display("FAIL pending_sweep_len got=%0d exp=784", n); end
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL pending_sweep_count got=%0d exp=0", pixel_count); end
        rd(16'd290, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL pending_sweep_read got=%h exp=0", d); end
    endtask

    task automatic test_clear_vs_write();
        int n;
        logic [31:0] d;
        wr_if.wr_x = 5'd1;
        wr_if.wr_y = 5'd1;
        wr_if.wr_value = 1'b1;
        wr_if.wr_valid = 1'b1;
        clear_req = 1'b1;
        #1;
        total++;
        if (wr_if.wr_ready !== 1'b0) begin bad++; $display("FAIL clr_vs_wr_ready got=%0b exp=0", wr_if.wr_ready); end
        step();
        clear_req = 1'b0;
        wr_if.wr_valid = 1'b0;
        total++;
        if (clearing !== 1'b1) begin bad++; $display("FAIL clr_vs_wr_clearing got=%0b exp=1", clearing); end
        wait_clear_done(n);
        total++;
        if (n != 784) begin bad++; $display("FAIL clr_vs_wr_len got=%0d exp=784", n); end
        total++;
        if (pixel_count !== 10'd0) begin bad++; $display("FAIL clr_vs_wr_count got=%0d exp=0", pixel_count); end
        rd(16'd29, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL clr_vs_wr_read got=%h exp=0", d); end
    endtask
`else
    task automatic test_brush();
        bit ok;
        int lc;
        logic [31:0] d;
        do_write(5'd0, 5'd0, 1'b1, ok, lc);
        total++;
        if (pixel_count !== 10'd4) begin bad++; $display("FAIL brush_corner_count got=%0d exp=4", pixel_count); end
        rd(16'd0, d);
        total++;
        if (d !== 32'h0001_0000) begin bad++; $display("FAIL brush_px0 got=%h exp=00010000", d); end
        rd(16'd29, d);
        total++;
        if (d !== 32'h0001_0000) begin bad++; $display("FAIL brush_px29 got=%h exp=00010000", d); end
        rd(16'd2, d);
        total++;
        if (d !== 32'h0) begin bad++; $display("FAIL brush_px2 got=%h exp=0", d); end
        do_write(5'd5, 5'd5, 1'b1, ok, lc);
        total++;
        if (pixel_count !== 10'd13) begin bad++; $display("FAIL brush_center_count got=%0d exp=13", pixel_count); end
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        resetn = 1'b1;
        clear_req = 1'b0;
        lock = 1'b0;
        read_addr = 16'd0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_x = 5'd0;
        wr_if.wr_y = 5'd0;
        wr_if.wr_value = 1'b0;

        test_reset();
        test_clear_sweep();
        test_reset_mid_sweep();
        test_read_all_zero();
`ifndef MNIST_IMG_BRUSH_3X3_EN
        test_write_single();
        test_repeat_and_erase();
        test_out_of_range();
        test_lock_clear();
        test_clear_vs_write();
`else
        test_brush();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
